// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Decode-to-execute pipeline register for a 5-stage RISC pipeline. Selects
//   ALU operands (with EX/MEM and MEM/WB forwarding), detects load-use
//   hazards against the instruction currently held, and registers the
//   operands and control flags for the execute stage.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid                   decode presents an instruction
//   in_rs/in_rt/in_rd          source / destination register numbers
//   in_rs_data/in_rt_data      register-file read data
//   in_imm, in_shamt           immediate and shift amount
//   in_srca_sel                0 = rs, 1 = zero-extended shamt
//   in_srcb_sel                00 = rt, 01 = sext imm, 10 = zext imm, 11 = {imm,16'h0}
//   in_alufunc                 ALU function code (passed through)
//   in_regwrite/memread/memwrite  control flags
//   stall, flush               hold stage / replace contents with a bubble
//   exmem_*, memwb_*           forwarding sources
//   out_*                      registered operands and control for execute
//   load_use_hazard            combinational stall request to decode
//   bubble_count               saturating count of load-use bubbles
module alu_operand_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [15:0] in_imm,
  input  logic [4:0]  in_shamt,
  input  logic        in_srca_sel,
  input  logic [1:0]  in_srcb_sel,
  input  logic [5:0]  in_alufunc,
  input  logic        in_regwrite,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_store_data,
  output logic [5:0]  out_alufunc,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,
  output logic        out_memread,
  output logic        out_memwrite,
  output logic        load_use_hazard,
  output logic [15:0] bubble_count
);

  logic        r_vld_p1;
  logic [31:0] r_a_p1;
  logic [31:0] r_b_p1;
  logic [31:0] r_store_p1;
  logic [5:0]  r_func_p1;
  logic [4:0]  r_rd_p1;
  logic        r_regwrite_p1;
  logic        r_memread_p1;
  logic        r_memwrite_p1;
  logic [15:0] r_bubble_cnt;

  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_hazard;

  // EX/MEM has the younger result, so it wins over MEM/WB. Register 0 is
  // hard-wired to zero and is never a forwarding target.
  function automatic logic [31:0] fwd_sel(input logic [4:0] src,
                                          input logic [31:0] rf_data);
    logic [31:0] val;
    val = rf_data;
    if (FWD_EN && src != 5'd0) begin
      if (exmem_regwrite && exmem_rd == src)
        val = exmem_result;
      else if (memwb_regwrite && memwb_rd == src)
        val = memwb_result;
    end
    return val;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_comb begin
    w_fwd_rs = fwd_sel(in_rs, in_rs_data);
    w_fwd_rt = fwd_sel(in_rt, in_rt_data);
    w_a = in_srca_sel ? {27'h0, in_shamt} : w_fwd_rs;
    case (in_srcb_sel)
      2'b00:   w_b = w_fwd_rt;
      2'b01:   w_b = {{16{in_imm[15]}}, in_imm};
      2'b10:   w_b = {16'h0, in_imm};
      default: w_b = {in_imm, 16'h0};
    endcase
  end

  // rt only matters when it is actually read as an ALU operand or as store data.
  assign w_hazard = r_vld_p1 & r_memread_p1 & (r_rd_p1 != 5'd0) & in_valid &
                    ((r_rd_p1 == in_rs) |
                     ((r_rd_p1 == in_rt) & ((in_srcb_sel == 2'b00) | in_memwrite)));

  // ---- decode -> execute register (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_a_p1        <= 32'h0;
      r_b_p1        <= 32'h0;
      r_store_p1    <= 32'h0;
      r_func_p1     <= 6'h00;
      r_rd_p1       <= 5'd0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_bubble_cnt  <= 16'h0;
    end else if (flush) begin
      r_vld_p1      <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_memwrite_p1 <= 1'b0;
    end else if (stall) begin
      r_vld_p1 <= r_vld_p1;
    end else if (w_hazard) begin
      r_vld_p1      <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_bubble_cnt  <= sat_inc(r_bubble_cnt);
    end else begin
      r_vld_p1      <= in_valid;
      r_a_p1        <= w_a;
      r_b_p1        <= w_b;
      r_store_p1    <= w_fwd_rt;
      r_func_p1     <= in_alufunc;
      r_rd_p1       <= in_rd;
      r_regwrite_p1 <= in_valid & in_regwrite;
      r_memread_p1  <= in_valid & in_memread;
      r_memwrite_p1 <= in_valid & in_memwrite;
    end
  end

  assign out_valid       = r_vld_p1;
  assign out_a           = r_a_p1;
  assign out_b           = r_b_p1;
  assign out_store_data  = r_store_p1;
  assign out_alufunc     = r_func_p1;
  assign out_rd          = r_rd_p1;
  assign out_regwrite    = r_regwrite_p1;
  assign out_memread     = r_memread_p1;
  assign out_memwrite    = r_memwrite_p1;
  assign load_use_hazard = w_hazard;
  assign bubble_count    = r_bubble_cnt;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: FWD_EN, 1, 1 enables EX/MEM and MEM/WB forwarding; 0 passes register-file data unmodified.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  decode stage presents an instruction.
REQ-005 in_rs, in_rt, in_rd  in  5 each  source and destination register numbers.
REQ-006 in_rs_data, in_rt_data  in  32 each  register-file read data.
REQ-007 in_imm  in  16  instruction immediate; in_shamt  in  5  shift amount.
REQ-008 in_srca_sel  in  1  0=rs, 1=zero-extended shamt.
REQ-009 in_srcb_sel  in  2  00=rt, 01=sign-ext imm, 10=zero-ext imm, 11={imm,16'h0}.
REQ-010 in_alufunc  in  6  ALU function code, passed through.
REQ-011 in_regwrite, in_memread, in_memwrite  in  1 each  control flags.
REQ-012 stall  in  1  hold stage; flush  in  1  replace stage contents with bubble.
REQ-013 exmem_regwrite  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source.
REQ-014 memwb_regwrite  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source.
REQ-015 out_valid  out  1; out_a, out_b  out  32 each  ALU operands.
REQ-016 out_store_data  out  32  forwarded rt for stores; out_alufunc  out  6.
REQ-017 out_rd  out  5; out_regwrite, out_memread, out_memwrite  out  1 each.
REQ-018 load_use_hazard  out  1  combinational request for decode stage to stall.
REQ-019 bubble_count  out  16  saturating count of bubbles inserted.

Function
REQ-020 Forwarding per source: EX/MEM match (regwrite=1, rd!=0, rd==src) wins over MEM/WB match; otherwise register-file data; FWD_EN=0 disables both.
REQ-021 Register 0 shall never be forwarded; source 0 reads in_*_data unchanged.
REQ-022 Operand A = forwarded rs, or {27'h0,in_shamt} when in_srca_sel=1.
REQ-023 Operand B per in_srcb_sel using forwarded rt; sign extension replicates in_imm[15].
REQ-024 out_store_data = forwarded rt regardless of in_srcb_sel.
REQ-025 load_use_hazard = out_valid & out_memread & out_rd!=0 & in_valid & (out_rd==in_rs | (out_rd==in_rt & (in_srcb_sel==00 | in_memwrite))).
REQ-026 Per-edge priority: flush > stall > load_use_hazard > load.
REQ-027 Flush: out_valid, out_regwrite, out_memread, out_memwrite <= 0; other outputs unchanged; bubble_count not incremented.
REQ-028 Stall (no flush): all registered outputs hold; hazard output still evaluates combinationally.
REQ-029 Load-use hazard (no flush/stall): insert bubble as in REQ-027 and increment bubble_count.
REQ-030 Load: all outputs take computed values next edge; in_valid=0 loads a bubble with all control flags 0.
REQ-031 Latency exactly one cycle from accepted input to outputs.
REQ-032 bubble_count saturates at 16'hFFFF, never wraps.
REQ-033 Forwarding uses exmem/memwb values sampled at the loading edge, not earlier.

Reset
REQ-034 rst_n low shall immediately clear all registered outputs to 0, including bubble_count and out_alufunc=6'h00.
REQ-035 Reset mid-stall or mid-hazard discards the pending instruction; first edge after release performs a normal load.

Verification
REQ-036 in_rs=3, in_rs_data=5, exmem_rd=3, exmem_regwrite=1, exmem_result=0x11, memwb_rd=3, memwb_result=0x22 -> out_a=0x11 after one edge.
REQ-037 in_srcb_sel=01, in_imm=0x8000 -> out_b=0xFFFF8000; srcb_sel=11, imm=0x1234 -> out_b=0x12340000.
REQ-038 Load with out_rd=4, next instr in_rs=4 -> load_use_hazard=1, next edge out_valid=0, bubble_count=1; following edge loads instruction.
REQ-039 stall=1 and flush=1 same edge -> out_valid=0, bubble_count unchanged; stall alone -> outputs identical for held cycles.
REQ-040 exmem_rd=0, exmem_regwrite=1, in_rs=0, in_rs_data=0 -> out_a=0.
REQ-041 Drive 65540 load-use bubbles -> bubble_count=0xFFFF; assert rst_n low mid-cycle -> all outputs 0 before next edge.
